// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches the word at PC over a
// req/ack port, holds it for decode, and redirects the PC at each commit.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  input  logic        Stall,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] Inst,
  output logic        InstValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, ERROR} state_t;

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        merr_q, merr_d;
  logic        terr_q, terr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      merr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      merr_q  <= merr_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    merr_d  = merr_q;
    terr_d  = terr_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        // ack on the last allowed cycle is checked first so it beats timeout
        if (IMemAck) begin
          inst_d  = IMemData;
          state_d = EXEC;
        end else if (cnt_q == WMAX) begin
          terr_d  = 1'b1;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EXEC: begin
        if (!Stall) begin
          if (!NextPCSrc) begin
            pc_d    = pc_q + 32'd4;
            cnt_d   = '0;
            state_d = FETCH;
          end else if (BrTarget[1:0] == 2'b00) begin
            pc_d    = BrTarget;
            cnt_d   = '0;
            state_d = FETCH;
          end else begin
            merr_d  = 1'b1;
            state_d = ERROR;
          end
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = BOOT;
    endcase
  end

  assign IMemReq     = (state_q == FETCH);
  assign IMemAddr    = pc_q;
  assign InstValid   = (state_q == EXEC);
  assign Inst        = inst_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign MisalignErr = merr_q;
  assign TimeoutErr  = terr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: unit a (RESET_PC=0, WAIT_MAX=3) and
// unit b (RESET_PC=0xFFFF_FFFC, WAIT_MAX=15) share one clock.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, nps_a, stall_a, ack_a;
  logic [31:0] brt_a, data_a;
  logic        req_a, iv_a, me_a, te_a;
  logic [31:0] addr_a, inst_a, pc_a, pp4_a;

  logic        rst_b, nps_b, stall_b, ack_b;
  logic [31:0] brt_b, data_b;
  logic        req_b, iv_b, me_b, te_b;
  logic [31:0] addr_b, inst_b, pc_b, pp4_b;

  int vectors = 0;
  int errs    = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_MAX(3)) dut_a (
    .clk(clk), .rst_n(rst_a), .NextPCSrc(nps_a), .BrTarget(brt_a), .Stall(stall_a),
    .IMemAck(ack_a), .IMemData(data_a), .IMemReq(req_a), .IMemAddr(addr_a),
    .Inst(inst_a), .InstValid(iv_a), .PC(pc_a), .PCPlus4(pp4_a),
    .MisalignErr(me_a), .TimeoutErr(te_a)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .WAIT_MAX(15)) dut_b (
    .clk(clk), .rst_n(rst_b), .NextPCSrc(nps_b), .BrTarget(brt_b), .Stall(stall_b),
    .IMemAck(ack_b), .IMemData(data_b), .IMemReq(req_b), .IMemAddr(addr_b),
    .Inst(inst_b), .InstValid(iv_b), .PC(pc_b), .PCPlus4(pp4_b),
    .MisalignErr(me_b), .TimeoutErr(te_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch_a(input logic [31:0] d);
    ack_a = 1'b1; data_a = d;
    tick();
    ack_a = 1'b0;
  endtask

  task automatic commit_a(input logic n, input logic [31:0] t);
    stall_a = 1'b0; nps_a = n; brt_a = t;
    tick();
    nps_a = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".req"},  32'(req_a),  32'd0);
    chk({tag, ".addr"}, addr_a,      32'h0);
    chk({tag, ".pc"},   pc_a,        32'h0);
    chk({tag, ".pp4"},  pp4_a,       32'h4);
    chk({tag, ".inst"}, inst_a,      32'h0);
    chk({tag, ".iv"},   32'(iv_a),   32'd0);
    chk({tag, ".me"},   32'(me_a),   32'd0);
    chk({tag, ".te"},   32'(te_a),   32'd0);
  endtask

  initial begin
    int n;
    rst_a = 1'b0; nps_a = 1'b0; stall_a = 1'b0; ack_a = 1'b0; brt_a = '0; data_a = '0;
    rst_b = 1'b0; nps_b = 1'b0; stall_b = 1'b0; ack_b = 1'b0; brt_b = '0; data_b = '0;
    tick(); tick();
    chk_reset_a("rst_a");

    // sequential fetch, zero-wait memory
    rst_a = 1'b1;
    tick();
    chk("boot.req",  32'(req_a), 32'd1);
    chk("boot.addr", addr_a,     32'h0);
    chk("boot.iv",   32'(iv_a),  32'd0);
    fetch_a(32'hAAAA_0001);
    chk("i0.iv",   32'(iv_a),  32'd1);
    chk("i0.inst", inst_a,     32'hAAAA_0001);
    chk("i0.req",  32'(req_a), 32'd0);
    commit_a(1'b0, 32'h0);
    chk("i1.req",  32'(req_a), 32'd1);
    chk("i1.addr", addr_a,     32'h4);
    chk("i1.iv",   32'(iv_a),  32'd0);
    fetch_a(32'hAAAA_0002);
    chk("i1.inst", inst_a,     32'hAAAA_0002);
    commit_a(1'b0, 32'h0);
    chk("i2.addr", addr_a,     32'h8);
    fetch_a(32'hAAAA_0003);
    commit_a(1'b0, 32'h0);
    fetch_a(32'hAAAA_0004);
    commit_a(1'b0, 32'h0);
    fetch_a(32'hAAAA_0005);
    chk("i4.pc", pc_a, 32'h10);

    // stall with a pending branch, stray ack ignored in EXEC
    stall_a = 1'b1; nps_a = 1'b1; brt_a = 32'h100; ack_a = 1'b1; data_a = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pc",   pc_a,       32'h10);
      chk("stall.pp4",  pp4_a,      32'h14);
      chk("stall.iv",   32'(iv_a),  32'd1);
      chk("stall.inst", inst_a,     32'hAAAA_0005);
    end
    ack_a = 1'b0;
    commit_a(1'b1, 32'h100);
    chk("br.pc",   pc_a,       32'h100);
    chk("br.addr", addr_a,     32'h100);
    chk("br.req",  32'(req_a), 32'd1);

    // misaligned taken target
    fetch_a(32'hAAAA_0006);
    commit_a(1'b1, 32'h102);
    chk("mis.me",  32'(me_a),  32'd1);
    chk("mis.te",  32'(te_a),  32'd0);
    chk("mis.pc",  pc_a,       32'h100);
    chk("mis.req", 32'(req_a), 32'd0);
    chk("mis.iv",  32'(iv_a),  32'd0);
    ack_a = 1'b1;
    tick(); tick(); tick();
    ack_a = 1'b0;
    chk("mis.hold.me",  32'(me_a),  32'd1);
    chk("mis.hold.req", 32'(req_a), 32'd0);

    // reset out of ERROR
    rst_a = 1'b0;
    tick();
    chk_reset_a("rst_err");
    rst_a = 1'b1;
    tick();
    chk("rst_err.req",  32'(req_a), 32'd1);
    chk("rst_err.addr", addr_a,     32'h0);

    // timeout, WAIT_MAX=3: request high for exactly 4 cycles
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_a) n++;
      tick();
    end
    chk("to.reqcycles", 32'(n),     32'd4);
    chk("to.te",        32'(te_a),  32'd1);
    chk("to.me",        32'(me_a),  32'd0);
    chk("to.req",       32'(req_a), 32'd0);

    // reset mid-FETCH while waiting on ack
    rst_a = 1'b0; tick();
    rst_a = 1'b1; tick();
    tick(); tick();
    chk("midf.req", 32'(req_a), 32'd1);
    rst_a = 1'b0;
    tick();
    chk_reset_a("rst_fetch");
    rst_a = 1'b1;
    tick();
    chk("restart.addr", addr_a, 32'h0);

    // ack on the 4th (last allowed) cycle wins
    for (int i = 0; i < 3; i++) begin
      chk("late.req", 32'(req_a), 32'd1);
      tick();
    end
    fetch_a(32'hBBBB_0001);
    chk("late.iv",   32'(iv_a), 32'd1);
    chk("late.te",   32'(te_a), 32'd0);
    chk("late.inst", inst_a,    32'hBBBB_0001);

    // unit b: PC wrap
    chk("b.rst.pc",   pc_b,   32'hFFFF_FFFC);
    chk("b.rst.pp4",  pp4_b,  32'h0);
    chk("b.rst.addr", addr_b, 32'hFFFF_FFFC);
    rst_b = 1'b1;
    tick();
    chk("b.f.addr", addr_b, 32'hFFFF_FFFC);
    ack_b = 1'b1; data_b = 32'hCCCC_0001;
    tick();
    ack_b = 1'b0;
    chk("b.e.pp4",  pp4_b,  32'h0);
    chk("b.e.inst", inst_b, 32'hCCCC_0001);
    tick();
    chk("b.wrap.addr", addr_b,     32'h0);
    chk("b.wrap.pp4",  pp4_b,      32'h4);
    chk("b.wrap.req",  32'(req_b), 32'd1);

    // unit b timeout, WAIT_MAX=15: 16 request cycles
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (req_b) n++;
      tick();
    end
    chk("b.to.reqcycles", 32'(n),    32'd16);
    chk("b.to.te",        32'(te_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the processor. Holds the architectural PC, fetches the instruction at PC through a req/ack instruction-memory port, and presents it to decode. At each instruction commit it consumes the branch unit's NextPCSrc decision to pick PC+4 or the ALU-computed target. It also traps misaligned targets and memory timeouts.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- WAIT_MAX, 15: maximum no-ack FETCH cycles before timeout; range 1..255.

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- NextPCSrc  in  1  branch unit decision: 1 = take BrTarget
- BrTarget  in  32  jump/branch target from ALU; JALR bit0 already cleared upstream
- Stall  in  1  1 = hold current instruction (no commit)
- IMemAck  in  1  instruction memory: data valid this cycle
- IMemData  in  32  instruction word, valid when IMemAck=1
- IMemReq  out  1  fetch request
- IMemAddr  out  32  fetch address (= PC)
- Inst  out  32  instruction to decode
- InstValid  out  1  Inst/PC valid for execution
- PC  out  32  address of Inst
- PCPlus4  out  32  PC+4, for JAL/JALR link writeback
- MisalignErr  out  1  sticky: taken target not word-aligned
- TimeoutErr  out  1  sticky: no ack within WAIT_MAX+1 cycles

## Operation
- FSM states: BOOT, FETCH, EXEC, ERROR. All outputs are Moore decodes of registers; no input-to-output combinational path.
- BOOT: entered on reset. The next cycle moves to FETCH.
- FETCH:
  - IMemReq=1, IMemAddr=PC, both held stable until ack.
  - IMemAck=1: latch IMemData into Inst, go to EXEC.
  - Otherwise, increment the wait counter. If the counter already equals WAIT_MAX, go to ERROR and set TimeoutErr.
  - An ack on the final allowed cycle wins over timeout.
- EXEC: InstValid=1, IMemReq=0; IMemAck is ignored.
  - Stall=1: remain in EXEC. PC, Inst and the errors are unchanged, and NextPCSrc/BrTarget are ignored.
  - Stall=0 is the commit cycle; NextPCSrc and BrTarget are sampled at this edge.
  - NextPCSrc=0: PC <= PC+4, go to FETCH.
  - NextPCSrc=1 and BrTarget[1:0]==0: PC <= BrTarget, go to FETCH.
  - NextPCSrc=1 and BrTarget[1:0]!=0: PC unchanged, set MisalignErr, go to ERROR.
- ERROR: IMemReq=0, InstValid=0. Held until reset; the error flags stay set.
- Arithmetic: PCPlus4 = PC + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no flag). Wait counter is 8 bits and cleared on every entry to FETCH.
- Reset values (all outputs): PC=RESET_PC, PCPlus4=RESET_PC+4, IMemAddr=RESET_PC, Inst=0, InstValid=0, IMemReq=0, MisalignErr=0, TimeoutErr=0; counter=0; state=BOOT.
- Reset mid-operation: rst_n=0 at any edge, in any state, forces all reset values at that edge. An outstanding request is abandoned, and the memory must tolerate a dropped req.

## Timing
- Cycle 0 = first edge with rst_n=1: BOOT->FETCH. IMemReq rises after cycle 0.
- Zero-wait memory (ack in the first FETCH cycle): each instruction costs 2 cycles (FETCH, EXEC) plus any Stall cycles.
- Each no-ack FETCH cycle adds 1 cycle.
- New PC is visible on PC/IMemAddr the cycle after the commit edge.
- Timeout: with no ack, ERROR is entered at the edge of the (WAIT_MAX+1)th FETCH cycle.
- Simultaneous Stall=1 and NextPCSrc=1: Stall wins, no redirect. The decision is re-sampled at the actual commit.

## Test plan
- Reset then zero-wait memory, NextPCSrc=0 for 3 commits -> IMemAddr sequence 0x0, 0x4, 0x8. InstValid pulses 1 cycle per instruction; Inst equals the supplied IMemData.
- In EXEC at PC=0x10: Stall=1 for 3 cycles with NextPCSrc=1, BrTarget=0x100, then Stall=0, NextPCSrc=1 -> PC stays 0x10 during the stall, then PC=0x100 and next IMemAddr=0x100. PCPlus4=0x14 throughout EXEC.
- Commit with NextPCSrc=1, BrTarget=0x102 -> MisalignErr=1, state ERROR, PC unchanged, IMemReq stays 0 until reset.
- WAIT_MAX=3, ack withheld -> IMemReq high for exactly 4 cycles, then TimeoutErr=1. Separate run with ack on the 4th cycle -> normal EXEC, no error.
- RESET_PC=0xFFFF_FFFC, NextPCSrc=0 commit -> PCPlus4=0x0 and next fetch at 0x0000_0000.
- rst_n=0 for 1 cycle mid-FETCH (waiting on ack) and mid-ERROR -> all outputs return to reset values, and the fetch restarts at RESET_PC after BOOT.
